// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// The request fields are held stable from the start of an access until dmem_ack.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, req/ack load/store sequencing, pipeline stall and load extension.
// Optional MEM_MISALIGN_CHECK_EN: misaligned word/half accesses skip the bus and raise m_AdEL/m_AdES.
module mem_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] e_PC,
    input  logic [31:0] e_Instr,
    input  logic        e_RegWrite,
    input  logic [4:0]  e_WriteReg,
    input  logic [31:0] e_Eout,
    input  logic [31:0] e_RD2,
    input  logic [3:0]  e_MemOp,
    mem_stage_if.master dmem,
    output logic        m_stall,
    output logic [31:0] EXMEM_Eout,
    output logic [1:0]  M_Tnew,
    output logic [31:0] m_PC,
    output logic [31:0] m_Instr,
    output logic        m_RegWrite,
    output logic [4:0]  m_WriteReg,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic        m_AdEL,
    output logic        m_AdES,
`endif
    output logic [31:0] m_Mout
);

    typedef enum logic [3:0] {
        OP_NONE = 4'd0, OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
        OP_LBU  = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    state_e      state, state_nx;
    logic [31:0] exmem_pc, exmem_instr, exmem_rd2;
    logic        exmem_regwrite;
    logic [4:0]  exmem_writereg;
    logic [3:0]  exmem_memop;
    logic [31:0] load_buf, load_ext;
    logic        is_load, is_store, is_word, is_half, is_byte, sign_ext;
    logic        misalign, bus_req, capture, done_fault;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exmem_pc       <= RESET_PC;
            exmem_instr    <= '0;
            EXMEM_Eout     <= '0;
            exmem_rd2      <= '0;
            exmem_writereg <= '0;
            exmem_regwrite <= 1'b0;
            exmem_memop    <= '0;
        end else if (!m_stall) begin
            exmem_pc       <= e_PC;
            exmem_instr    <= e_Instr;
            EXMEM_Eout     <= e_Eout;
            exmem_rd2      <= e_RD2;
            exmem_writereg <= e_WriteReg;
            exmem_regwrite <= e_RegWrite;
            exmem_memop    <= e_MemOp;
        end
    end

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_word  = 1'b0;
        is_half  = 1'b0;
        is_byte  = 1'b0;
        sign_ext = 1'b0;
        case (exmem_memop)
            OP_LW:  begin is_load  = 1'b1; is_word = 1'b1; end
            OP_LH:  begin is_load  = 1'b1; is_half = 1'b1; sign_ext = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LB:  begin is_load  = 1'b1; is_byte = 1'b1; sign_ext = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
            OP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
            OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
            OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = (is_word && (EXMEM_Eout[1:0] != 2'b00)) || (is_half && EXMEM_Eout[0]);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        be_calc    = '0;
        wdata_calc = exmem_rd2;
        if (is_word) begin
            be_calc = 4'b1111;
        end else if (is_half) begin
            be_calc    = EXMEM_Eout[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{exmem_rd2[15:0]}};
        end else if (is_byte) begin
            be_calc    = 4'b0001 << EXMEM_Eout[1:0];
            wdata_calc = {4{exmem_rd2[7:0]}};
        end
    end

    always_comb begin
        rd_byte  = dmem.dmem_rdata[8*EXMEM_Eout[1:0] +: 8];
        rd_half  = EXMEM_Eout[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        load_ext = dmem.dmem_rdata;
        if (is_half)
            load_ext = {{16{sign_ext & rd_half[15]}}, rd_half};
        else if (is_byte)
            load_ext = {{24{sign_ext & rd_byte[7]}}, rd_byte};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // A misaligned access still stalls in IDLE so the faulting instruction stays in EX/MEM for DONE.
    always_comb begin
        state_nx = state;
        bus_req  = 1'b0;
        m_stall  = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: if (is_load || is_store) begin
                m_stall = 1'b1;
                if (misalign) begin
                    state_nx = DONE;
                end else begin
                    bus_req = 1'b1;
                    if (dmem.dmem_ack) begin
                        state_nx = DONE;
                        capture  = is_load;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                bus_req = 1'b1;
                m_stall = 1'b1;
                if (dmem.dmem_ack) begin
                    state_nx = DONE;
                    capture  = is_load;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        load_buf <= '0;
        else if (capture) load_buf <= load_ext;
    end

    assign done_fault = (state == DONE) && misalign;

    assign dmem.dmem_req   = bus_req;
    assign dmem.dmem_we    = bus_req & is_store;
    assign dmem.dmem_be    = bus_req ? be_calc : 4'b0000;
    assign dmem.dmem_addr  = {EXMEM_Eout[31:2], 2'b00};
    assign dmem.dmem_wdata = wdata_calc;

`ifdef MEM_MISALIGN_CHECK_EN
    assign m_AdEL = done_fault & is_load;
    assign m_AdES = done_fault & is_store;
`endif

    assign M_Tnew     = {1'b0, is_load && (state != DONE)};
    assign m_PC       = exmem_pc;
    assign m_Instr    = exmem_instr;
    assign m_RegWrite = exmem_regwrite & ~m_stall & ~done_fault;
    assign m_WriteReg = m_stall ? 5'd0 : exmem_writereg;
    assign m_Mout     = done_fault ? 32'd0 :
                        ((state == DONE) && is_load) ? load_buf : EXMEM_Eout;

endmodule
